l2_access_controller: RTL

- Sequencing FSM that drives the L2 data array (1024 lines × 512 bit, addressed by {index, way}) for each L1 request.
- Runs the tag-lookup cycle, dirty-victim writeback to memory, refill from memory, and the write-hit update.
- Returns a one-cycle response to L1.
- Sits between the L1 miss interface, the L2 tag/LRU array (which supplies the lookup results) and the memory port.

---
 rtl/l2_access_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/l2_access_controller.sv
// L2 access sequencer: lookup, dirty writeback, refill and write-hit update
// for one L1 request at a time, driving the {index, way} data array port.
module l2_access_controller #(
  parameter int INDEX_W = 8,
  parameter int WAY_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               req_valid_L1_L2,
  input  logic               req_write_L1_L2,
  input  logic [INDEX_W-1:0] req_index_L1_L2,
  input  logic               tag_hit,
  input  logic [WAY_W-1:0]   hit_way,
  input  logic [WAY_W-1:0]   victim_way,
  input  logic               victim_dirty,
  input  logic               mem_ack,
  output logic [INDEX_W-1:0] index_L1_L2,
  output logic [WAY_W-1:0]   way,
  output logic               update,
  output logic               refill,
  output logic               tag_install,
  output logic               set_dirty,
  output logic               mem_read_req,
  output logic               mem_write_req,
  output logic               resp_valid_L2_L1,
  output logic               busy,
  output logic [CNT_W-1:0]   miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_UPDATE,
    S_RESPOND
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               wr_q;
  logic               wr_nxt;
  logic [INDEX_W-1:0] idx_nxt;
  logic [WAY_W-1:0]   way_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      index_L1_L2 <= '0;
      way         <= '0;
      miss_count  <= '0;
    end else begin
      state       <= state_nxt;
      wr_q        <= wr_nxt;
      index_L1_L2 <= idx_nxt;
      way         <= way_nxt;
      miss_count  <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_q;
    idx_nxt   = index_L1_L2;
    way_nxt   = way;
    cnt_nxt   = miss_count;
    unique case (state)
      S_IDLE: begin
        if (req_valid_L1_L2) begin
          wr_nxt    = req_write_L1_L2;
          idx_nxt   = req_index_L1_L2;
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (tag_hit) begin
          way_nxt   = hit_way;
          state_nxt = wr_q ? S_UPDATE : S_RESPOND;
        end else begin
          way_nxt   = victim_way;
          if (miss_count != CNT_MAX)
            cnt_nxt = miss_count + 1'b1;
          state_nxt = victim_dirty ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        if (mem_ack)
          state_nxt = S_REFILL;
      end
      S_REFILL: begin
        if (mem_ack)
          state_nxt = wr_q ? S_UPDATE : S_RESPOND;
      end
      S_UPDATE:  state_nxt = S_RESPOND;
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // refill/tag_install follow mem_ack so the array captures memory data
  // on the same edge that completes the read.
  assign mem_write_req    = (state == S_WRITEBACK);
  assign mem_read_req     = (state == S_REFILL);
  assign refill           = (state == S_REFILL) & mem_ack;
  assign tag_install      = (state == S_REFILL) & mem_ack;
  assign update           = (state == S_UPDATE);
  assign set_dirty        = (state == S_UPDATE);
  assign resp_valid_L2_L1 = (state == S_RESPOND);
  assign busy             = (state != S_IDLE);

endmodule
